leds_pwm: RTL
=============

// Module: leds_pwm
// PURPOSE
//  Memory-mapped LED peripheral on the CPU I/O bus; successor of the single 8-bit LED latch.
//  Drives N_CH LEDs, each with on/off enable, 8-bit PWM brightness and optional blink.
//  Registers occupy BASE_ADDR .. BASE_ADDR+3+N_CH-1; a write to offset 0 keeps the old
//  "write a byte, LEDs show it" usage.
// PARAMETERS
//  BASE_ADDR  8'h0A  first bus address of the register window
//  N_CH       8      LED channel count, legal 1..8
//  BLINK_DIV  4      PWM periods per blink half-period, legal 1..255
// PORTS
//  clk       in   1     system clock
//  rst       in   1     synchronous reset, active-high
//  addr      in   8     bus address
//  write_en  in   1     write strobe, one cycle per write
//  din       in   8     write data
//  dout      out  8     read data for addressed register, combinational
//  leds      out  N_CH  LED drive, registered
// BEHAVIOUR
//  Register map (offset = addr - BASE_ADDR):
//   0 DATA [N_CH-1:0]  per-channel enable.                           reset 0
//   1 BLINK[N_CH-1:0]  per-channel blink enable.                     reset 0
//   2 PRESC[7:0]       PWM step = PRESC+1 clk cycles.                reset 0
//   3+i DUTY_i[7:0]    brightness of channel i; 0 = off, FF = full.  reset FF
//  Writes:
//   - Take effect at the clk edge where write_en=1 and the offset is in range.
//   - Out-of-window writes are ignored; bits above N_CH in DATA/BLINK write as 0.
//  Reads: dout = addressed register, zero-extended. Out-of-window address -> 8'h00.
//  Prescaler:
//   - presc_cnt counts 0..PRESC; tick=1 when presc_cnt==PRESC, then presc_cnt wraps to 0.
//   - A write to PRESC clears presc_cnt in that same edge.
//  PWM counter:
//   - pwm_cnt 8-bit, increments on tick, wraps FF->00 ("period start").
//   - At period start, each duty_act_i <= DUTY_i (shadow). A mid-period DUTY write is
//     therefore invisible until the next period; no glitches.
//   - pwm_on_i = (duty_act_i==FF) | (pwm_cnt < duty_act_i).
//  Blink:
//   - blink_cnt counts period starts 0..BLINK_DIV-1.
//   - At its wrap, blink_phase toggles; blink_phase resets to 1.
//  Output: leds[i] <= DATA[i] & pwm_on_i & (~BLINK[i] | blink_phase).
//   - One-cycle latency from any state change to the pin.
//  Reset:
//   - All counters 0, blink_phase=1, duty_act=FF, leds=0.
//   - Reset mid-period aborts the period; output is 0 the cycle after rst.
//  Simultaneous DUTY write and period start: the shadow takes the OLD DUTY value;
//  the new value applies next period.
// STRUCTURE
//  - leds_pwm_defs.vh: offsets OFS_DATA=0, OFS_BLINK=1, OFS_PRESC=2, OFS_DUTY0=3;
//    DUTY_FULL=8'hFF.
//  - Sub-module leds_pwm_channel: DUTY reg, shadow, comparator, output flop.
//    Instantiated N_CH times via generate.
//  - Top level owns address decode, DATA/BLINK/PRESC, prescaler, pwm_cnt, blink logic.
// TESTING
//  1 Reset, write DATA=8'hA5 at 0x0A, PRESC=0 -> leds==8'hA5 two cycles after write;
//    read 0x0A -> 8'hA5.
//  2 DUTY_0=8'h40 at 0x0D, DATA=1 -> after the next period start, leds[0] high
//    64 of every 256 cycles.
//  3 Mid-period write DUTY_0=8'h10 -> duty stays 8'h40 until pwm_cnt wraps, then 16/256.
//  4 BLINK=1, BLINK_DIV=4, PRESC=0 -> leds[0] gated: 1024 cycles on, 1024 off.
//  5 Write at 0x09 and 0x0A+3+N_CH -> no register changes; reads there return 8'h00.
//  6 Assert rst mid-period with leds active -> next cycle leds==0, all registers at reset values.

Source files
------------

// File: rtl/leds_pwm_pkg.sv
// Shared register offsets, constants and the PWM compare helper for the
// leds_pwm LED peripheral.
package leds_pwm_pkg;

  // Register offsets relative to BASE_ADDR.
  localparam logic [7:0] OFS_DATA  = 8'd0;
  localparam logic [7:0] OFS_BLINK = 8'd1;
  localparam logic [7:0] OFS_PRESC = 8'd2;
  localparam logic [7:0] OFS_DUTY0 = 8'd3;

  // A duty value of all ones means "always on" rather than 255/256.
  localparam logic [7:0] DUTY_FULL = 8'hFF;

  // PWM compare: full duty is solid on, otherwise on while the counter is
  // below the active duty value (duty 0 is therefore solid off).
  function automatic logic pwm_on(input logic [7:0] duty_act,
                                  input logic [7:0] cnt);
    return (duty_act == DUTY_FULL) || (cnt < duty_act);
  endfunction

endpackage

// File: rtl/leds_pwm_channel.sv
// One LED channel: DUTY register, period-aligned shadow copy, comparator and
// the registered LED drive.
module leds_pwm_channel
  import leds_pwm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       duty_we,
  input  logic [7:0] din,
  input  logic       period_start,
  input  logic [7:0] pwm_cnt,
  input  logic       gate,
  output logic [7:0] duty,
  output logic       led
);

  logic [7:0] duty_act;

  // Bus-visible DUTY register, written directly by the CPU.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty <= DUTY_FULL;
    end else if (duty_we) begin
      duty <= din;
    end
  end

  // Shadow copy loaded only at period start; a write landing on that same
  // edge is not yet in duty, so the old value is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_act <= DUTY_FULL;
    end else if (period_start) begin
      duty_act <= duty;
    end
  end

  // Registered LED drive: enable/blink gate ANDed with the PWM compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= 1'b0;
    end else begin
      led <= gate & pwm_on(duty_act, pwm_cnt);
    end
  end

endmodule

// File: rtl/leds_pwm.sv
// Memory-mapped LED peripheral: N_CH channels with enable, 8-bit PWM
// brightness and optional blink. Owns address decode, DATA/BLINK/PRESC,
// the prescaler, the shared PWM counter and the blink timebase.
//
// Bus handshake: there is no valid/ready pair. A write is a single-cycle
// write_en pulse and always completes on that clock edge; reads are purely
// combinational from addr, so dout is valid in the same cycle addr is.
module leds_pwm
  import leds_pwm_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h0A,
  parameter int          N_CH      = 8,
  parameter int          BLINK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      addr,
  input  logic            write_en,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  output logic [N_CH-1:0] leds
);

  localparam logic [7:0] WIN_SIZE   = 8'(3 + N_CH);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);

  // Address decode
  logic [7:0]      offset;
  logic            in_window;
  logic            wr;
  logic            wr_data;
  logic            wr_blink;
  logic            wr_presc;
  logic [N_CH-1:0] wr_duty;

  // Control registers
  logic [N_CH-1:0] data;
  logic [N_CH-1:0] blink;
  logic [7:0]      presc;

  // Timebase
  logic [7:0]      presc_cnt;
  logic            tick;
  logic [7:0]      pwm_cnt;
  logic            period_start;
  logic [7:0]      blink_cnt;
  logic            blink_phase;

  // Per-channel wiring
  logic [N_CH-1:0] gate;
  logic [7:0]      duty_bus [N_CH];

  // The lower bound check keeps addresses below the window from wrapping
  // into it through the subtraction.
  assign offset    = addr - BASE_ADDR;
  assign in_window = (addr >= BASE_ADDR) && (offset < WIN_SIZE);
  assign wr        = write_en & in_window;
  assign wr_data   = wr & (offset == OFS_DATA);
  assign wr_blink  = wr & (offset == OFS_BLINK);
  assign wr_presc  = wr & (offset == OFS_PRESC);

  // DATA register: per-channel enable; offset-0 writes act as the old latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (wr_data) begin
      data <= din[N_CH-1:0];
    end
  end

  // BLINK register: per-channel blink enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink <= '0;
    end else if (wr_blink) begin
      blink <= din[N_CH-1:0];
    end
  end

  // PRESC register: PWM step length minus one.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (wr_presc) begin
      presc <= din;
    end
  end

  assign tick = (presc_cnt == presc);

  // Prescaler: counts 0..presc, restarted whenever PRESC is rewritten so a
  // new step length starts from a clean boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (wr_presc || tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 8'd1;
    end
  end

  assign period_start = tick & (pwm_cnt == 8'hFF);

  // Shared PWM counter: one step per tick, natural FF->00 wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Blink timebase: counts PWM periods and flips the phase every BLINK_DIV.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (period_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  // Channel array: each gets its own DUTY write strobe and enable gate.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr_duty[i] = wr & (offset == OFS_DUTY0 + 8'(i));
    assign gate[i]    = data[i] & (~blink[i] | blink_phase);

    leds_pwm_channel u_ch (
      .clk          (clk),
      .rst          (rst),
      .duty_we      (wr_duty[i]),
      .din          (din),
      .period_start (period_start),
      .pwm_cnt      (pwm_cnt),
      .gate         (gate[i]),
      .duty         (duty_bus[i]),
      .led          (leds[i])
    );
  end

  // Read mux: zero-extended register value, 0 outside the window.
  always_comb begin
    dout = 8'h00;
    if (in_window) begin
      if (offset == OFS_DATA) begin
        dout = 8'(data);
      end else if (offset == OFS_BLINK) begin
        dout = 8'(blink);
      end else if (offset == OFS_PRESC) begin
        dout = presc;
      end else begin
        for (int i = 0; i < N_CH; i++) begin
          if (offset == OFS_DUTY0 + 8'(i)) begin
            dout = duty_bus[i];
          end
        end
      end
    end
  end

endmodule
